// File: rtl/mac_tx_framer.sv
// Byte-wide Ethernet MAC transmit framer: preamble/SFD insertion, zero padding,
// CRC-32 FCS generation and inter-frame gap enforcement ahead of the RGMII stage.
module mac_tx_framer #(
    parameter int PREAMBLE_LEN  = 7,
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_LEN       = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       mac_phy_txen,
    output logic [7:0] mac_phy_txd,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [10:0] CNT_MAX  = 11'h7FF;
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_LEN);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // The good FCS is the inverted register; an aborted frame sends the
    // register as-is, which is exactly the complement of the good FCS.
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc_reg, input logic [1:0] idx,
                                            input logic bad);
        logic [31:0] fcs;
        fcs = bad ? crc_reg : ~crc_reg;
        return fcs[{idx, 3'b000} +: 8];
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [1:0]  fcs_idx_q, fcs_idx_d;
    logic        fcs_bad_q, fcs_bad_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic        underrun_q, underrun_d;
    logic [10:0] byte_cnt_inc;

    assign byte_cnt_inc = (byte_cnt_q == CNT_MAX) ? CNT_MAX : (byte_cnt_q + 11'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= 8'd0;
            ifg_cnt_q  <= 8'd0;
            fcs_idx_q  <= 2'd0;
            fcs_bad_q  <= 1'b0;
            txd_q      <= 8'h00;
            txen_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            ifg_cnt_q  <= ifg_cnt_d;
            fcs_idx_q  <= fcs_idx_d;
            fcs_bad_q  <= fcs_bad_d;
            txd_q      <= txd_d;
            txen_q     <= txen_d;
            underrun_q <= underrun_d;
        end
    end

    // Datapath state is (re)initialised at every frame start, so it needs no reset.
    always_ff @(posedge clk) begin
        byte_cnt_q <= byte_cnt_d;
        crc_q      <= crc_d;
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        ifg_cnt_d  = ifg_cnt_q;
        fcs_idx_d  = fcs_idx_q;
        fcs_bad_d  = fcs_bad_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d    = (PREAMBLE_LEN > 1) ? S_PREAMBLE : S_SFD;
                    pre_cnt_d  = 8'd1;
                    byte_cnt_d = 11'd0;
                    crc_d      = CRC_INIT;
                    fcs_idx_d  = 2'd0;
                    fcs_bad_d  = 1'b0;
                end
            end
            S_PREAMBLE: begin
                pre_cnt_d = pre_cnt_q + 8'd1;
                if (pre_cnt_q >= PRE_LAST) begin
                    state_d = S_SFD;
                end
            end
            S_SFD: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (s_valid) begin
                    crc_d      = crc32_byte(crc_q, s_data);
                    byte_cnt_d = byte_cnt_inc;
                    if (s_last) begin
                        state_d   = (byte_cnt_inc < MIN_LEN) ? S_PAD : S_FCS;
                        fcs_idx_d = 2'd0;
                    end
                end else begin
                    // Underrun: FCS byte 0 leaves this cycle, the rest follow from S_FCS.
                    state_d   = S_FCS;
                    fcs_bad_d = 1'b1;
                    fcs_idx_d = 2'd1;
                end
            end
            S_PAD: begin
                crc_d      = crc32_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_inc;
                if (byte_cnt_inc >= MIN_LEN) begin
                    state_d   = S_FCS;
                    fcs_idx_d = 2'd0;
                end
            end
            S_FCS: begin
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (fcs_idx_q == 2'd3) begin
                    state_d   = S_IFG;
                    ifg_cnt_d = 8'd0;
                end
            end
            S_IFG: begin
                ifg_cnt_d = ifg_cnt_q + 8'd1;
                if (ifg_cnt_q >= IFG_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Each state decides the byte that appears on the PHY side one cycle later.
    always_comb begin
        txd_d      = 8'h00;
        txen_d     = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    txd_d  = PRE_BYTE;
                    txen_d = 1'b1;
                end
            end
            S_PREAMBLE: begin
                txd_d  = PRE_BYTE;
                txen_d = 1'b1;
            end
            S_SFD: begin
                txd_d  = SFD_BYTE;
                txen_d = 1'b1;
            end
            S_DATA: begin
                txen_d = 1'b1;
                if (s_valid) begin
                    txd_d = s_data;
                end else begin
                    txd_d      = fcs_byte(crc_q, 2'd0, 1'b1);
                    underrun_d = 1'b1;
                end
            end
            S_PAD: begin
                txd_d  = 8'h00;
                txen_d = 1'b1;
            end
            S_FCS: begin
                txd_d  = fcs_byte(crc_q, fcs_idx_q, fcs_bad_q);
                txen_d = 1'b1;
            end
            default: begin
                txd_d  = 8'h00;
                txen_d = 1'b0;
            end
        endcase
    end

    assign s_ready      = (state_q == S_DATA);
    assign busy         = (state_q != S_IDLE);
    assign mac_phy_txen = txen_q;
    assign mac_phy_txd  = txd_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: a frame-level model queues the expected
// PHY byte stream and a monitor checks it, plus s_ready/busy/IFG behaviour.
module tb_mac_tx_framer;

    localparam int          PRE     = 7;
    localparam int          MINL    = 60;
    localparam int          IFG     = 12;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic       txen;
    logic [7:0] txd;
    logic       busy;
    logic       underrun;

    mac_tx_framer #(
        .PREAMBLE_LEN (PRE),
        .MIN_FRAME_LEN(MINL),
        .IFG_LEN      (IFG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .mac_phy_txen(txen),
        .mac_phy_txd (txd),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #4 clk = ~clk;

    typedef struct {
        int len;
        bit aborted;
        int total;
    } frame_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] crc_tab[256];
    logic [7:0]  frm[2048];
    logic [7:0]  exp_q[$];
    frame_t      frame_q[$];

    frame_t      cur;
    int          pos = 0;
    int          gap = 0;
    bit          in_frame = 0;
    bit          gap_valid = 0;
    logic [31:0] run_crc = 32'hFFFFFFFF;
    logic [31:0] last_residue = 32'h0;
    int          last_total = 0;
    int          last_gap = 0;
    int          underrun_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int req_min);
        n_checks++;
        if (act < req_min) begin
            n_fail++;
            $display("FAIL %s: got %0d, required at least %0d (t=%0t)", name, act, req_min, $time);
        end
    endtask

    function automatic void build_tab();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    endfunction

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        return crc_tab[c[7:0] ^ b] ^ (c >> 8);
    endfunction

    // Expected on-wire frame: preamble, SFD, payload, pad to minimum, FCS (LSB first).
    task automatic push_model(input int len, input bit aborted);
        logic [31:0] crc;
        logic [31:0] fcs;
        int          n;
        frame_t      f;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(frm[i]);
            crc = crc_next(crc, frm[i]);
        end
        n = len;
        if (!aborted) begin
            while (n < MINL) begin
                exp_q.push_back(8'h00);
                crc = crc_next(crc, 8'h00);
                n++;
            end
        end
        fcs = crc ^ 32'hFFFFFFFF;
        if (aborted) fcs = ~fcs;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(fcs >> (8 * k)));
        f.len     = len;
        f.aborted = aborted;
        f.total   = PRE + 1 + n + 4;
        frame_q.push_back(f);
    endtask

    // Called at posedge+1; returns at posedge+1 after the last byte is accepted
    // (or once stop_at bytes have gone). hold leaves s_valid high for the next frame.
    task automatic send_frame(input int len, input int stop_at, input bit hold);
        int idx;
        int guard;
        bit acc;
        bit stop;
        idx   = 0;
        guard = 0;
        stop  = (stop_at >= 0);
        push_model(stop ? stop_at : len, stop);
        while (idx < len && !(stop && idx == stop_at) && guard < 10000) begin
            s_valid = 1'b1;
            s_data  = frm[idx];
            s_last  = (idx == len - 1);
            acc     = s_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        if (guard >= 10000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: accepted %0d of %0d bytes", idx, len);
        end
        s_last = 1'b0;
        if (!hold || stop) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((frame_q.size() != 0 || exp_q.size() != 0 || in_frame || (gap_valid && gap <= IFG))
               && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: pending frames %0d, pending bytes %0d", frame_q.size(),
                     exp_q.size());
        end
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txen"}, txen, 0);
        check({tag, "_txd"}, txd, 0);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            frame_q.delete();
            in_frame  = 0;
            gap_valid = 0;
            gap       = 0;
            pos       = 0;
        end else begin
            if (underrun) begin
                underrun_cnt++;
                check("underrun_position", (in_frame && cur.aborted && pos == PRE + 1 + cur.len), 1);
            end
            if (txen) begin
                if (!in_frame) begin
                    if (frame_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_start: txen high with no frame queued (t=%0t)", $time);
                        cur.len = 0;
                        cur.aborted = 0;
                        cur.total = 0;
                    end else begin
                        cur = frame_q.pop_front();
                    end
                    if (gap_valid) check_ge("ifg_length", gap, IFG);
                    last_gap = gap;
                    in_frame = 1;
                    pos      = 0;
                    run_crc  = 32'hFFFFFFFF;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL txd_extra: got 0x%0h, required txen=0 (t=%0t)", txd, $time);
                end else begin
                    check("txd", txd, exp_q.pop_front());
                end
                check("busy_tx", busy, 1);
                check("s_ready_window", s_ready,
                      (pos >= PRE && pos <= PRE - 1 + cur.len + (cur.aborted ? 1 : 0)));
                if (pos >= PRE + 1) run_crc = crc_next(run_crc, txd);
                pos++;
            end else begin
                if (in_frame) begin
                    check("frame_length", pos, cur.total);
                    last_total   = pos;
                    last_residue = run_crc;
                    in_frame     = 0;
                    gap          = 0;
                    gap_valid    = 1;
                end
                gap++;
                check("s_ready_idle", s_ready, 0);
                check("txd_idle", txd, 0);
                check("busy_idle", busy, gap_valid ? (gap < IFG) : 0);
            end
        end
    end

    initial begin
        int uc0;
        int len;
        build_tab();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++) frm[i] = 8'(i);
        send_frame(64, -1, 0);
        wait_idle();
        check("f64_txen_cycles", last_total, 76);
        check("f64_residue", last_residue, RESIDUE);

        for (int i = 0; i < 9; i++) frm[i] = 8'(8'h31 + i);
        send_frame(9, -1, 0);
        wait_idle();
        check("f9_txen_cycles", last_total, 72);
        check("f9_residue", last_residue, RESIDUE);

        fill_random(60);
        send_frame(60, -1, 1);
        fill_random(60);
        send_frame(60, -1, 0);
        wait_idle();
        check("b2b_gap", last_gap, IFG);

        uc0 = underrun_cnt;
        fill_random(100);
        send_frame(100, 20, 0);
        wait_idle();
        check("ur_pulses", underrun_cnt - uc0, 1);
        check("ur_txen_cycles", last_total, PRE + 1 + 20 + 4);
        check("ur_residue_bad", (last_residue != RESIDUE), 1);

        uc0 = underrun_cnt;
        fill_random(100);
        send_frame(100, 30, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midreset");
        repeat (5) @(posedge clk);
        #1;
        fill_random(45);
        send_frame(45, -1, 0);
        wait_idle();
        check("midreset_next_len", last_total, PRE + 1 + MINL + 4);
        check("midreset_no_underrun", underrun_cnt - uc0, 0);

        for (int f = 0; f < 10; f++) begin
            case (f)
                0: len = 1;
                1: len = 59;
                2: len = 61;
                default: len = int'($urandom_range(1, 1500));
            endcase
            fill_random(len);
            send_frame(len, -1, ($urandom_range(0, 1) == 1));
            if (!s_valid) begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        wait_idle();
        check("total_underruns", underrun_cnt, 1);
        check("frames_left", frame_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
- Byte-wide Ethernet MAC transmit framer. Sits directly upstream of the RGMII transmit stage and drives its mac_phy_txen / mac_phy_txd inputs.
- Accepts a frame (destination MAC through end of payload) over a valid/ready byte stream.
- Emits preamble, SFD, data, zero padding to the minimum length, and the FCS, then enforces the inter-frame gap.
- One byte per clk cycle (gigabit rate).

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD
- MIN_FRAME_LEN, 60, minimum bytes before FCS; short frames are zero-padded up to this
- IFG_LEN, 12, idle cycles (txen=0) after the last FCS byte before the next preamble may start

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_data  input  8  frame byte from upstream
- s_valid  input  1  s_data valid
- s_last  input  1  qualifies the final frame byte (sampled with s_valid & s_ready)
- s_ready  output  1  framer accepts s_data this cycle
- mac_phy_txen  output  1  transmit enable to RGMII stage
- mac_phy_txd  output  8  transmit byte to RGMII stage
- busy  output  1  high in every state except IDLE
- underrun  output  1  one-cycle pulse when a frame is aborted by underrun

Behaviour:
- Reset:
  - Outputs go to mac_phy_txen=0, mac_phy_txd=0x00, s_ready=0, busy=0, underrun=0 on the cycle after rst is sampled high.
  - State returns to IDLE.
  - Reset mid-frame truncates the frame immediately; no FCS and no IFG are sent.
- State machine: IDLE -> PREAMBLE -> SFD -> DATA -> [PAD] -> FCS -> IFG -> IDLE.
- mac_phy_txd and mac_phy_txen are registered.
- Timing:
  - T0: IDLE with s_valid=1 sampled.
  - T1..T7: txen=1, txd=0x55.
  - T8: txd=0xD5.
  - s_ready is high from T8 through the cycle s_last is accepted.
  - A byte accepted in cycle N appears on txd in cycle N+1.
- s_ready:
  - Driven only by state; it never depends combinationally on s_valid.
  - Low in IDLE, PREAMBLE, PAD, FCS and IFG.
- DATA rules:
  - Upstream must hold s_valid high for every byte from the first through s_last.
  - s_valid=0 while s_ready=1 is an underrun. The framer then:
    - pulses underrun;
    - goes straight to FCS;
    - sends the bitwise complement of the correct FCS, so the receiver drops the frame;
    - then runs the IFG.
- Byte counter:
  - 11 bits, counting data+pad bytes; saturates at 2047.
  - No maximum-length check.
- PAD: entered after s_last if count < MIN_FRAME_LEN. Sends 0x00 until count reaches MIN_FRAME_LEN.
- CRC:
  - IEEE 802.3 CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
  - Covers data+pad only; preamble/SFD are excluded.
  - Updated one byte per cycle, combinationally from the current register and byte.
- FCS: 4 bytes, least-significant byte of the final CRC first, with txen=1.
- IFG:
  - IFG_LEN cycles with txen=0, txd=0x00.
  - s_valid is ignored; the next preamble starts no earlier than the cycle after IFG ends.
- s_valid in IDLE with s_last=1 is a 1-byte frame, padded to MIN_FRAME_LEN.
- busy=1 from T1 through the last IFG cycle.

Test Plan:
- 64-byte frame, bytes 0x00..0x3F, s_valid continuous:
  - txd shows 7×0x55, 0xD5, 64 data bytes, 4 FCS bytes; txen high exactly 76 cycles.
  - Running CRC register over data+FCS ends at residue 0xDEBB20E3.
- 9-byte frame "123456789" (0x31..0x39):
  - Followed by 51 × 0x00 pad bytes.
  - FCS matches the bench CRC model over the 60 bytes; total txen-high = 72 cycles.
- Back-to-back: two 60-byte frames with s_valid held high between them.
  - Exactly 12 cycles of txen=0 between the last FCS byte and the second 0x55.
  - s_ready=0 throughout the IFG.
- Underrun: drop s_valid after byte 20 of a 100-byte frame.
  - underrun pulses once; 4 FCS bytes follow immediately.
  - They equal ~CRC over the 20 bytes; the residue check fails.
  - Then 12 idle cycles.
- Reset mid-DATA at byte 30:
  - Next cycle txen=0, txd=0x00, s_ready=0, busy=0.
  - A new frame afterwards starts cleanly with 7×0x55.
- Random backpressure-free frames of 1..1500 bytes against the reference model:
  - Byte-exact txd/txen match; no s_ready outside DATA.
